// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single memory port between an instruction-fetch
// requester and a data requester. Round-robin arbitration with at most one
// outstanding transaction, registered memory-side outputs, and an optional
// busy timeout that completes the transaction with zero data and an err pulse.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we_re,
    input  logic [3:0]  dm_mask,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_request,
    output logic        mem_we_re,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic        err,
    output logic        stall_if,
    output logic        stall_dm
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_BUSY = 2'd1,
        S_DM_BUSY = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_grant_if;
    logic        w_grant_dm;
    logic        w_done;
    logic        w_timeout;

    // 1 = the data port won the most recent grant, so fetch wins the next tie
    logic        r_last_dm;
    logic [15:0] r_cnt;

    logic        r_mem_request;
    logic        r_mem_we_re;
    logic [3:0]  r_mem_mask;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        r_if_valid;
    logic        r_dm_valid;
    logic        r_err;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/timeout detection while busy
    always_comb begin
        w_state_next = r_state;
        w_grant_if   = 1'b0;
        w_grant_dm   = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (if_req && dm_req) begin
                    if (r_last_dm) begin
                        w_grant_if = 1'b1;
                    end else begin
                        w_grant_dm = 1'b1;
                    end
                end else if (if_req) begin
                    w_grant_if = 1'b1;
                end else if (dm_req) begin
                    w_grant_dm = 1'b1;
                end
                if (w_grant_if) begin
                    w_state_next = S_IF_BUSY;
                end else if (w_grant_dm) begin
                    w_state_next = S_DM_BUSY;
                end
            end
            S_IF_BUSY, S_DM_BUSY: begin
                if (mem_valid) begin
                    w_done       = 1'b1;
                    w_state_next = S_RESP;
                end else if ((TIMEOUT_W != 16'd0) && ((r_cnt + 16'd1) == TIMEOUT_W)) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latch the granted request, capture response, pulse valid/err in RESP
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_dm     <= 1'b1;
            r_cnt         <= 16'd0;
            r_mem_request <= 1'b0;
            r_mem_we_re   <= 1'b0;
            r_mem_mask    <= 4'd0;
            r_mem_address <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_if_rdata    <= 32'd0;
            r_dm_rdata    <= 32'd0;
            r_if_valid    <= 1'b0;
            r_dm_valid    <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            r_err      <= 1'b0;
            if (w_grant_if) begin
                r_last_dm     <= 1'b0;
                r_cnt         <= 16'd0;
                r_mem_request <= 1'b1;
                r_mem_we_re   <= 1'b0;
                r_mem_mask    <= 4'b1111;
                r_mem_address <= if_addr;
                r_mem_wdata   <= 32'd0;
            end else if (w_grant_dm) begin
                r_last_dm     <= 1'b1;
                r_cnt         <= 16'd0;
                r_mem_request <= 1'b1;
                r_mem_we_re   <= dm_we_re;
                r_mem_mask    <= dm_mask;
                r_mem_address <= dm_addr;
                r_mem_wdata   <= dm_wdata;
            end else if (w_done || w_timeout) begin
                r_mem_request <= 1'b0;
                r_err         <= w_timeout;
                if (r_state == S_IF_BUSY) begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= w_done ? mem_rdata : 32'd0;
                end else begin
                    // Stores and timed-out loads return zero
                    r_dm_valid <= 1'b1;
                    r_dm_rdata <= (w_done && !r_mem_we_re) ? mem_rdata : 32'd0;
                end
            end else if ((r_state == S_IF_BUSY) || (r_state == S_DM_BUSY)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign mem_request = r_mem_request;
    assign mem_we_re   = r_mem_we_re;
    assign mem_mask    = r_mem_mask;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign if_rdata    = r_if_rdata;
    assign if_valid    = r_if_valid;
    assign dm_rdata    = r_dm_rdata;
    assign dm_valid    = r_dm_valid;
    assign err         = r_err;
    assign stall_if    = if_req & ~r_if_valid;
    assign stall_dm    = dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (TIMEOUT = 4). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we_re;
    logic [3:0]  dm_mask;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_request;
    logic        mem_we_re;
    logic [3:0]  mem_mask;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        err;
    logic        stall_if;
    logic        stall_dm;

    int checks;
    int errors;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .dm_req      (dm_req),
        .dm_we_re    (dm_we_re),
        .dm_mask     (dm_mask),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_valid    (dm_valid),
        .mem_request (mem_request),
        .mem_we_re   (mem_we_re),
        .mem_mask    (mem_mask),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .err         (err),
        .stall_if    (stall_if),
        .stall_dm    (stall_dm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land on the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b0; dm_we_re = 1'b0;
        dm_mask = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0; mem_valid = 1'b0;
        tick(); tick();
        checks++;
        if ({mem_request, mem_we_re, mem_mask, if_valid, dm_valid, err} !== 9'd0) begin
            errors++; $display("FAIL reset_ctrl got %b required 0", {mem_request, mem_we_re, mem_mask, if_valid, dm_valid, err});
        end
        checks++;
        if ({mem_address, mem_wdata, if_rdata, dm_rdata} !== 128'd0) begin
            errors++; $display("FAIL reset_data got %h required 0", {mem_address, mem_wdata, if_rdata, dm_rdata});
        end
        checks++;
        if (stall_if !== 1'b1 || stall_dm !== 1'b0) begin
            errors++; $display("FAIL reset_stall got if=%b dm=%b required if=1 dm=0", stall_if, stall_dm);
        end
        if_req = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    // Both requesters contend three times: fetch, data, fetch
    task automatic test_arbitration();
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we_re = 1'b0; dm_mask = 4'hF; dm_addr = 32'h800;
        tick();
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 32'h400) begin
            errors++; $display("FAIL arb_first got req=%b addr=%h required req=1 addr=00000400", mem_request, mem_address);
        end
        mem_valid = 1'b1; mem_rdata = 32'h11;
        tick();
        checks++;
        if (if_valid !== 1'b1 || dm_valid !== 1'b0 || if_rdata !== 32'h11 || stall_dm !== 1'b1) begin
            errors++; $display("FAIL arb_first_done got ifv=%b dmv=%b rd=%h sdm=%b required 1 0 00000011 1", if_valid, dm_valid, if_rdata, stall_dm);
        end
        mem_valid = 1'b0; if_addr = 32'h404;
        tick();
        checks++;
        if (mem_request !== 1'b0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL arb_resp_gap got req=%b ifv=%b required 0 0", mem_request, if_valid);
        end
        tick();
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 32'h800) begin
            errors++; $display("FAIL arb_second got req=%b addr=%h required req=1 addr=00000800", mem_request, mem_address);
        end
        mem_valid = 1'b1; mem_rdata = 32'h22;
        tick();
        checks++;
        if (dm_valid !== 1'b1 || dm_rdata !== 32'h22 || if_valid !== 1'b0) begin
            errors++; $display("FAIL arb_second_done got dmv=%b rd=%h ifv=%b required 1 00000022 0", dm_valid, dm_rdata, if_valid);
        end
        mem_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 32'h404) begin
            errors++; $display("FAIL arb_third got req=%b addr=%h required req=1 addr=00000404", mem_request, mem_address);
        end
        mem_valid = 1'b1; mem_rdata = 32'h33;
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h33 || dm_rdata !== 32'h22) begin
            errors++; $display("FAIL arb_third_done got ifv=%b ifrd=%h dmrd=%h required 1 00000033 00000022", if_valid, if_rdata, dm_rdata);
        end
        mem_valid = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 32'h100 || mem_we_re !== 1'b0 || mem_mask !== 4'hF || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL fetch_req got req=%b addr=%h we=%b mask=%h wd=%h required 1 00000100 0 f 00000000", mem_request, mem_address, mem_we_re, mem_mask, mem_wdata);
        end
        checks++;
        if (stall_if !== 1'b1 || if_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_stall got stall=%b v=%b required 1 0", stall_if, if_valid);
        end
        mem_valid = 1'b1; mem_rdata = 32'h00500093;
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h00500093 || mem_request !== 1'b0 || err !== 1'b0 || stall_if !== 1'b0) begin
            errors++; $display("FAIL fetch_done got v=%b rd=%h req=%b err=%b stall=%b required 1 00500093 0 0 0", if_valid, if_rdata, mem_request, err, stall_if);
        end
        mem_valid = 1'b0; if_req = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (if_valid !== 1'b0 || if_rdata !== 32'h00500093) begin
            errors++; $display("FAIL fetch_hold got v=%b rd=%h required 0 00500093", if_valid, if_rdata);
        end
    endtask

    // Load with one wait cycle: attributes stay stable until mem_valid
    task automatic test_load();
        dm_req = 1'b1; dm_we_re = 1'b0; dm_mask = 4'hF; dm_addr = 32'h3000; dm_wdata = 32'h0;
        tick();
        dm_req = 1'b0;
        tick();
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 32'h3000 || mem_we_re !== 1'b0 || dm_valid !== 1'b0) begin
            errors++; $display("FAIL load_wait got req=%b addr=%h we=%b v=%b required 1 00003000 0 0", mem_request, mem_address, mem_we_re, dm_valid);
        end
        mem_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        checks++;
        if (dm_valid !== 1'b1 || dm_rdata !== 32'hCAFEF00D || if_rdata !== 32'h00500093 || if_valid !== 1'b0) begin
            errors++; $display("FAIL load_done got v=%b rd=%h ifrd=%h ifv=%b required 1 cafef00d 00500093 0", dm_valid, dm_rdata, if_rdata, if_valid);
        end
        mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_we_re = 1'b1; dm_mask = 4'b0011; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
        tick();
        checks++;
        if (mem_request !== 1'b1 || mem_we_re !== 1'b1 || mem_mask !== 4'b0011 || mem_address !== 32'h2000 || mem_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_req got req=%b we=%b mask=%b addr=%h wd=%h required 1 1 0011 00002000 deadbeef", mem_request, mem_we_re, mem_mask, mem_address, mem_wdata);
        end
        mem_valid = 1'b1; mem_rdata = 32'h12345678;
        tick();
        checks++;
        if (dm_valid !== 1'b1 || dm_rdata !== 32'h0 || mem_request !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL store_done got v=%b rd=%h req=%b err=%b required 1 00000000 0 0", dm_valid, dm_rdata, mem_request, err);
        end
        mem_valid = 1'b0; dm_req = 1'b0; dm_we_re = 1'b0;
        tick();
        checks++;
        if (dm_valid !== 1'b0) begin
            errors++; $display("FAIL store_pulse got v=%b required 0", dm_valid);
        end
    endtask

    task automatic test_idle_mem_valid();
        mem_valid = 1'b1; mem_rdata = 32'hA5A5A5A5;
        tick(); tick();
        checks++;
        if (if_valid !== 1'b0 || dm_valid !== 1'b0 || mem_request !== 1'b0 || if_rdata !== 32'h00500093) begin
            errors++; $display("FAIL idle_ignore got ifv=%b dmv=%b req=%b ifrd=%h required 0 0 0 00500093", if_valid, dm_valid, mem_request, if_rdata);
        end
        mem_valid = 1'b0;
    endtask

    // Load that never gets a response: four busy cycles, then err with zero data
    task automatic test_timeout();
        dm_req = 1'b1; dm_we_re = 1'b0; dm_mask = 4'hF; dm_addr = 32'h5000;
        tick();
        dm_req = 1'b0;
        // seed dm_rdata with nonzero data first
        mem_valid = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_valid = 1'b0;
        tick();
        dm_req = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_request !== 1'b1 || dm_valid !== 1'b0 || err !== 1'b0) begin
                errors++; $display("FAIL timeout_busy%0d got req=%b v=%b err=%b required 1 0 0", i, mem_request, dm_valid, err);
            end
            tick();
        end
        checks++;
        if (dm_valid !== 1'b1 || err !== 1'b1 || dm_rdata !== 32'h0 || mem_request !== 1'b0) begin
            errors++; $display("FAIL timeout_done got v=%b err=%b rd=%h req=%b required 1 1 00000000 0", dm_valid, err, dm_rdata, mem_request);
        end
        dm_req = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0 || dm_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse got err=%b v=%b required 0 0", err, dm_valid);
        end
        tick();
        checks++;
        if (mem_request !== 1'b0) begin
            errors++; $display("FAIL timeout_idle got req=%b required 0", mem_request);
        end
    endtask

    task automatic test_reset_mid();
        dm_req = 1'b1; dm_we_re = 1'b0; dm_addr = 32'h6000;
        tick();
        checks++;
        if (mem_request !== 1'b1) begin
            errors++; $display("FAIL rmid_busy got req=%b required 1", mem_request);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1; dm_req = 1'b0;
        checks++;
        if (mem_request !== 1'b0 || dm_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_reset got req=%b v=%b required 0 0", mem_request, dm_valid);
        end
        mem_valid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_valid = 1'b0;
        tick();
        checks++;
        if (mem_request !== 1'b0 || dm_valid !== 1'b0 || dm_rdata !== 32'h0) begin
            errors++; $display("FAIL rmid_ignore got req=%b v=%b rd=%h required 0 0 00000000", mem_request, dm_valid, dm_rdata);
        end
        dm_req = 1'b1; dm_addr = 32'h6004;
        tick();
        checks++;
        if (mem_request !== 1'b1 || mem_address !== 32'h6004) begin
            errors++; $display("FAIL rmid_next got req=%b addr=%h required 1 00006004", mem_request, mem_address);
        end
        dm_req = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h99;
        tick();
        mem_valid = 1'b0;
        checks++;
        if (dm_valid !== 1'b1 || dm_rdata !== 32'h99) begin
            errors++; $display("FAIL rmid_done got v=%b rd=%h required 1 00000099", dm_valid, dm_rdata);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        @(negedge clk);
        test_reset();
        test_arbitration();
        test_fetch();
        test_load();
        test_store();
        test_idle_mem_valid();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
